// File: rtl/bug_rom_arbiter_if.sv
// rtl/bug_rom_arbiter_if.sv - Requester/ROM bus bundle for bug_rom_arbiter (counter ports under BUG_ROM_ARB_CNT_EN)
interface bug_rom_arbiter_if;
   logic        req0;
   logic [11:0] addr0;
   logic        req1;
   logic [11:0] addr1;
   logic        gnt0;
   logic        gnt1;
   logic [11:0] rom_addr;
   logic [11:0] rom_rgb;
   logic [11:0] rgb;
   logic        vld0;
   logic        vld1;
`ifdef BUG_ROM_ARB_CNT_EN
   logic [15:0] gnt_cnt0;
   logic [15:0] gnt_cnt1;

   modport master (
      output req0, addr0, req1, addr1, rom_rgb,
      input  gnt0, gnt1, rom_addr, rgb, vld0, vld1, gnt_cnt0, gnt_cnt1
   );
   modport slave (
      input  req0, addr0, req1, addr1, rom_rgb,
      output gnt0, gnt1, rom_addr, rgb, vld0, vld1, gnt_cnt0, gnt_cnt1
   );
`else
   modport master (
      output req0, addr0, req1, addr1, rom_rgb,
      input  gnt0, gnt1, rom_addr, rgb, vld0, vld1
   );
   modport slave (
      input  req0, addr0, req1, addr1, rom_rgb,
      output gnt0, gnt1, rom_addr, rgb, vld0, vld1
   );
`endif
endinterface

// File: rtl/bug_rom_arbiter.sv
// rtl/bug_rom_arbiter.sv - Two-requester round-robin sprite ROM arbiter; grant counters under BUG_ROM_ARB_CNT_EN
module bug_rom_arbiter (
   input  logic               clk,
   input  logic               rst,
   bug_rom_arbiter_if.slave   bus
);
   logic        w_gnt0;
   logic        w_gnt1;
   // 1 = requester 1 was granted most recently, so requester 0 wins the next tie
   logic        r_last_gnt;
   // {req1, req0} grant tag for the read whose ROM data arrives this cycle
   logic [1:0]  r_tag1;
   logic        r_vld0;
   logic        r_vld1;
   logic [11:0] r_rgb;

   // Round-robin grant: sole requester wins, ties go to whoever was not served last
   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (!rst) begin
         if (bus.req0 && (!bus.req1 || r_last_gnt)) begin
            w_gnt0 = 1'b1;
         end else if (bus.req1) begin
            w_gnt1 = 1'b1;
         end
      end
   end

   assign bus.gnt0     = w_gnt0;
   assign bus.gnt1     = w_gnt1;
   assign bus.rom_addr = w_gnt0 ? bus.addr0 : (w_gnt1 ? bus.addr1 : 12'h000);
   assign bus.rgb      = r_rgb;
   assign bus.vld0     = r_vld0;
   assign bus.vld1     = r_vld1;

   // Pointer update plus two-stage tag pipeline aligned with the ROM read latency
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_gnt <= 1'b1;
         r_tag1     <= 2'b00;
         r_vld0     <= 1'b0;
         r_vld1     <= 1'b0;
         r_rgb      <= 12'h000;
      end else begin
         if (w_gnt0 || w_gnt1) begin
            r_last_gnt <= w_gnt1;
         end
         r_tag1 <= {w_gnt1, w_gnt0};
         r_vld0 <= r_tag1[0];
         r_vld1 <= r_tag1[1];
         if (|r_tag1) begin
            r_rgb <= bus.rom_rgb;
         end
      end
   end

`ifdef BUG_ROM_ARB_CNT_EN
   logic [15:0] r_cnt0;
   logic [15:0] r_cnt1;

   assign bus.gnt_cnt0 = r_cnt0;
   assign bus.gnt_cnt1 = r_cnt1;

   // Per-requester grant counters that stick at all-ones
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt0 <= 16'h0000;
         r_cnt1 <= 16'h0000;
      end else begin
         if (w_gnt0 && (r_cnt0 != 16'hFFFF)) begin
            r_cnt0 <= r_cnt0 + 16'h0001;
         end
         if (w_gnt1 && (r_cnt1 != 16'hFFFF)) begin
            r_cnt1 <= r_cnt1 + 16'h0001;
         end
      end
   end
`endif
endmodule
